fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
Program-counter and fetch-sequencing stage that sits directly upstream of the instruction-fetch stage. It drives the word address into the fetch stage, which has a synchronous instruction ROM followed by an output register, giving 2 cycles from address to instruction.
It keeps a 2-deep tag pipeline (PC plus valid) aligned with that latency, so downstream receives the PC and a valid flag for each instruction. It handles taken-branch/jump redirects, decode back-pressure by replay, halt/resume, and a fetch performance counter.

Parameters:
PC_W, 15, PC/ROM word-address width (ROM address is a word index; +1 per instruction)
RESET_PC, 0, PC value loaded on reset
CNT_W, 32, fetch counter width

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
stall_i  in  1  decode did not accept the instruction presented this cycle
redirect_i  in  1  taken branch/jump from execute
redirect_pc_i  in  PC_W  redirect target word address
halt_i  in  1  decode found a valid halt instruction at the fetch output
resume_i  in  1  leave HALT state
pc_o  out  PC_W  fetch address to the fetch stage (registered)
pc_if_o  out  PC_W  PC of the instruction currently at the fetch-stage output
inst_valid_o  out  1  instruction at the fetch output is valid, on the correct path, and not replayed
halted_o  out  1  unit is in HALT
fetch_cnt_o  out  CNT_W  number of issued fetches, saturating

Behaviour:
- State encoding: RUN, HOLD, HALT.
- issue = (state==RUN) and no redirect/halt/replay event this cycle.
- Tag pipeline:
  - t1 <= {pc_o, issue} each edge.
  - t2 <= t1 each edge.
  - pc_if_o = t2.pc; inst_valid_o = t2.v.
- Reset (async): pc_o=RESET_PC; t1.v=t2.v=0; t1.pc=t2.pc=0; state=RUN; halted_o=0; fetch_cnt_o=0. Hence inst_valid_o=0 and pc_if_o=0.
- Latency: a PC issued at edge k has inst_valid_o=1 and pc_if_o=that PC after edge k+1, the same cycle the fetch stage presents its instruction.
- After reset release: first valid output (pc_if_o=RESET_PC) follows the 2nd edge.
- Event priority per cycle: redirect_i > halt_i > replay (stall_i & inst_valid_o) > normal.
- RUN, normal: pc_o <= pc_o+1, modulo 2^PC_W (0x7FFF wraps to 0x0000); fetch_cnt_o += 1, saturating at all-ones.
- Redirect (RUN or HOLD):
  - pc_o <= redirect_pc_i; t1.v <= 0; t2.v <= 0; state <= RUN; no count.
  - The instruction presented during the redirect cycle is wrong-path; downstream flushes it on redirect_i.
  - Next fetch is redirect_pc_i, valid 2 edges after that issue.
- Halt (RUN, halt_i=1):
  - pc_o <= pc_if_o+1; t1.v, t2.v <= 0; state <= HALT; halted_o <= 1.
- HALT:
  - pc_o held; no issue; counter held; redirect_i, halt_i and stall_i ignored.
  - resume_i=1 -> RUN, halted_o <= 0; fetching restarts at the held pc_o on the next cycle.
- Replay (RUN, stall_i=1 and inst_valid_o=1):
  - pc_o <= pc_if_o; t1.v <= 0; t2.v <= 0; state <= HOLD.
- HOLD:
  - pc_o held; no issue.
  - stall_i=0 -> RUN; the first re-issue happens in that RUN cycle.
  - stall_i=1 -> stay in HOLD.
- stall_i while inst_valid_o=0: no effect.
- resume_i outside HALT: ignored.
- Reset mid-operation: all state returns to reset values immediately; in-flight tags are discarded.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
1. Reset release, no events:
   - pc_o steps 0,1,2,…
   - inst_valid_o rises after the 2nd edge with pc_if_o=0, then 1,2,… every cycle.
   - fetch_cnt_o increments each cycle.
2. Redirect while pc_o=5, target 0x0040:
   - Next cycle pc_o=0x0040 and inst_valid_o=0 for 2 cycles.
   - Then pc_if_o=0x0040 valid; counter not incremented in the redirect cycle.
3. stall_i=1 for 3 cycles while pc_if_o=7 is valid:
   - pc_o rewinds to 7; state HOLD; inst_valid_o=0.
   - After stall_i drops, pc_if_o=7 reappears valid exactly 2 cycles after re-issue; no PC skipped or duplicated as valid.
4. Halt at pc_if_o=0x0012:
   - halted_o=1; pc_o=0x0013 held; inst_valid_o=0; redirect_i ignored while halted.
   - resume_i -> fetch resumes at 0x0013.
5. Simultaneous redirect_i, halt_i and stall_i:
   - Redirect wins; halted_o stays 0; pc_o=target.
6. Wrap and saturation: RESET_PC=0x7FFE gives pc_o 0x7FFE, 0x7FFF, 0x0000. Preloading fetch_cnt_o near all-ones via CNT_W=4 gives saturation at 15.

Source files
------------

// File: rtl/fetch_pc_unit_if.sv
// Fetch PC unit bus: decode/execute controls in, fetch address and tag out.
interface fetch_pc_unit_if #(
    parameter int unsigned PC_W  = 15,
    parameter int unsigned CNT_W = 32
) ();
    logic            stall;
    logic            redirect;
    logic [PC_W-1:0] redirect_pc;
    logic            halt;
    logic            resume;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_if;
    logic            inst_valid;
    logic            halted;
    logic [CNT_W-1:0] fetch_cnt;

    modport master (
        output stall, redirect, redirect_pc, halt, resume,
        input  pc, pc_if, inst_valid, halted, fetch_cnt
    );

    modport slave (
        input  stall, redirect, redirect_pc, halt, resume,
        output pc, pc_if, inst_valid, halted, fetch_cnt
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// Program counter and fetch sequencing with a 2-deep PC/valid tag pipeline
// matching the fetch stage's 2-cycle ROM latency.
module fetch_pc_unit #(
    parameter int unsigned     PC_W     = 15,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int unsigned     CNT_W    = 32
) (
    input logic            clk,
    input logic            rst,
    fetch_pc_unit_if.slave bus
);

    typedef enum logic [1:0] {RUN, HOLD, HALT} state_t;

    state_t           state, state_n;
    logic [PC_W-1:0]  pc, pc_n;
    logic [PC_W-1:0]  t1_pc, t2_pc;
    logic             t1_v, t2_v;
    logic [CNT_W-1:0] cnt;
    logic             ev_redirect, ev_halt, ev_replay, flush, issue;

    // Event decode in priority order: redirect > halt > replay > normal issue.
    always_comb begin
        ev_redirect = bus.redirect && (state != HALT);
        ev_halt     = bus.halt && (state == RUN) && !bus.redirect;
        ev_replay   = bus.stall && t2_v && (state == RUN) && !bus.redirect && !bus.halt;
        flush       = ev_redirect || ev_halt || ev_replay;
        issue       = (state == RUN) && !flush;
    end

    // Next PC and next state selection.
    always_comb begin
        state_n = state;
        pc_n    = pc;
        if (ev_redirect) begin
            pc_n    = bus.redirect_pc;
            state_n = RUN;
        end else if (ev_halt) begin
            pc_n    = t2_pc + 1'b1;
            state_n = HALT;
        end else if (ev_replay) begin
            pc_n    = t2_pc;
            state_n = HOLD;
        end else begin
            case (state)
                RUN:  pc_n = pc + 1'b1;
                HOLD: if (!bus.stall) state_n = RUN;
                HALT: if (bus.resume) state_n = RUN;
                default: state_n = RUN;
            endcase
        end
    end

    // State, PC, tag pipeline and fetch counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            pc    <= RESET_PC;
            t1_pc <= '0;
            t1_v  <= 1'b0;
            t2_pc <= '0;
            t2_v  <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            t1_pc <= pc;
            t1_v  <= issue;
            t2_pc <= t1_pc;
            // Any flush event also kills the tag that would reach the output next.
            t2_v  <= t1_v && !flush;
            if (issue && (cnt != '1)) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign bus.pc         = pc;
    assign bus.pc_if      = t2_pc;
    assign bus.inst_valid = t2_v;
    assign bus.halted     = (state == HALT);
    assign bus.fetch_cnt  = cnt;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench: two parameterisations driven with the same stimulus
// and compared each cycle against an event-level reference model.
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [14:0] redirect_pc = '0;
    logic        halt = 1'b0;
    logic        resume = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    fetch_pc_unit_if #(.PC_W(15), .CNT_W(32)) bus_a ();
    fetch_pc_unit_if #(.PC_W(15), .CNT_W(4))  bus_b ();

    assign bus_a.stall       = stall;
    assign bus_a.redirect    = redirect;
    assign bus_a.redirect_pc = redirect_pc;
    assign bus_a.halt        = halt;
    assign bus_a.resume      = resume;
    assign bus_b.stall       = stall;
    assign bus_b.redirect    = redirect;
    assign bus_b.redirect_pc = redirect_pc;
    assign bus_b.halt        = halt;
    assign bus_b.resume      = resume;

    fetch_pc_unit #(.PC_W(15), .RESET_PC(15'h0000), .CNT_W(32)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    fetch_pc_unit #(.PC_W(15), .RESET_PC(15'h7FFE), .CNT_W(4)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    always #5 clk = ~clk;

    // Reference model: index 0 -> dut_a, index 1 -> dut_b.
    localparam int unsigned PC_MASK = 32'h7FFF;
    int unsigned     m_reset_pc [2] = '{32'h0000, 32'h7FFE};
    longint unsigned m_cmax     [2] = '{64'hFFFF_FFFF, 64'd15};
    int unsigned     m_pc       [2];
    int unsigned     m_fl_pc    [2];
    bit              m_fl_v     [2];
    int unsigned     m_out_pc   [2];
    bit              m_out_v    [2];
    bit              m_halted   [2];
    bit              m_holding  [2];
    longint unsigned m_cnt      [2];

    function automatic void model_reset(int i);
        m_pc[i]      = m_reset_pc[i];
        m_fl_pc[i]   = 0;
        m_fl_v[i]    = 0;
        m_out_pc[i]  = 0;
        m_out_v[i]   = 0;
        m_halted[i]  = 0;
        m_holding[i] = 0;
        m_cnt[i]     = 0;
    endfunction

    // One clock of the model: the address launched now reaches the output
    // after the following edge, unless a flush event discards it.
    function automatic void model_step(int i);
        int unsigned launch_pc = m_pc[i];
        bit          launched  = 0;
        bit          flushed   = 0;
        if (m_halted[i]) begin
            if (resume) m_halted[i] = 0;
        end else if (redirect) begin
            flushed      = 1;
            m_pc[i]      = 32'(redirect_pc);
            m_holding[i] = 0;
        end else if (m_holding[i]) begin
            if (!stall) m_holding[i] = 0;
        end else if (halt) begin
            flushed     = 1;
            m_pc[i]     = (m_out_pc[i] + 1) & PC_MASK;
            m_halted[i] = 1;
        end else if (stall && m_out_v[i]) begin
            flushed      = 1;
            m_pc[i]      = m_out_pc[i];
            m_holding[i] = 1;
        end else begin
            launched = 1;
            m_pc[i]  = (m_pc[i] + 1) & PC_MASK;
            if (m_cnt[i] < m_cmax[i]) m_cnt[i] = m_cnt[i] + 1;
        end
        m_out_pc[i] = m_fl_pc[i];
        m_out_v[i]  = m_fl_v[i] && !flushed;
        m_fl_pc[i]  = launch_pc;
        m_fl_v[i]   = launched;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at t=%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    task automatic check_outputs();
        check("a.pc",         32'(bus_a.pc),         m_pc[0]);
        check("a.pc_if",      32'(bus_a.pc_if),      m_out_pc[0]);
        check("a.inst_valid", 32'(bus_a.inst_valid), 32'(m_out_v[0]));
        check("a.halted",     32'(bus_a.halted),     32'(m_halted[0]));
        check("a.fetch_cnt",  32'(bus_a.fetch_cnt),  32'(m_cnt[0]));
        check("b.pc",         32'(bus_b.pc),         m_pc[1]);
        check("b.pc_if",      32'(bus_b.pc_if),      m_out_pc[1]);
        check("b.inst_valid", 32'(bus_b.inst_valid), 32'(m_out_v[1]));
        check("b.halted",     32'(bus_b.halted),     32'(m_halted[1]));
        check("b.fetch_cnt",  32'(bus_b.fetch_cnt),  32'(m_cnt[1]));
    endtask

    task automatic tick(input bit st, input bit rd, input logic [14:0] tgt,
                        input bit hl, input bit rs);
        stall       = st;
        redirect    = rd;
        redirect_pc = tgt;
        halt        = hl;
        resume      = rs;
        model_step(0);
        model_step(1);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(0, 0, '0, 0, 0);
    endtask

    task automatic random_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            tick($urandom_range(3, 0) == 0, $urandom_range(11, 0) == 0,
                 15'($urandom), $urandom_range(15, 0) == 0,
                 $urandom_range(2, 0) == 0);
        end
    endtask

    initial begin
        model_reset(0);
        model_reset(1);
        repeat (2) @(negedge clk);
        check_outputs();
        check("reset.b.pc", 32'(bus_b.pc), 32'h7FFE);
        rst = 1'b0;

        // Plain fetch from reset; pc_if reaches 7 after 9 edges.
        idle(9);
        check("run.a.pc_if", 32'(bus_a.pc_if), 32'h7);

        // Three-cycle stall with pc_if=7 valid, then release.
        tick(1, 0, '0, 0, 0);
        check("replay.a.pc", 32'(bus_a.pc), 32'h7);
        tick(1, 0, '0, 0, 0);
        tick(1, 0, '0, 0, 0);
        idle(5);

        // Redirect to 0x0040.
        tick(0, 1, 15'h0040, 0, 0);
        check("redirect.a.pc", 32'(bus_a.pc), 32'h40);
        idle(4);

        // Halt with pc_if=0x0012; redirect ignored while halted; resume.
        tick(0, 1, 15'h0010, 0, 0);
        idle(4);
        check("pre_halt.a.pc_if", 32'(bus_a.pc_if), 32'h12);
        tick(0, 0, '0, 1, 0);
        check("halt.a.pc", 32'(bus_a.pc), 32'h13);
        check("halt.a.halted", 32'(bus_a.halted), 32'h1);
        tick(1, 1, 15'h0300, 1, 0);
        idle(2);
        tick(0, 0, '0, 0, 1);
        idle(4);

        // Redirect, halt and stall together: redirect wins.
        tick(1, 1, 15'h0200, 1, 0);
        check("combo.a.halted", 32'(bus_a.halted), 32'h0);
        check("combo.a.pc", 32'(bus_a.pc), 32'h200);
        idle(3);

        random_ticks(400);

        // Asynchronous reset in mid-operation, away from any clock edge.
        #2 rst = 1'b1;
        stall = 1'b0; redirect = 1'b0; halt = 1'b0; resume = 1'b0;
        #1;
        model_reset(0);
        model_reset(1);
        check_outputs();
        @(negedge clk);
        rst = 1'b0;
        idle(20);
        check("sat.b.fetch_cnt", 32'(bus_b.fetch_cnt), 32'hF);
        random_ticks(400);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
